// File: rtl/macrocell_bank.sv
// Bank of NCELLS macrocells: product-term sum with cascade chain, 4-mode register, OE select.
// Optional pad keeper flop per cell enabled by defining MACROCELL_BANK_PIN_KEEPER_EN.
module macrocell_bank #(
   parameter int NCELLS  = 16,
   parameter int GOE_W   = 6,
   parameter int OESEL_W = 4
) (
   input  logic                        gclk_v,
   input  logic                        gclr_v,
   input  logic [5*NCELLS-1:0]         pt_v,
   input  logic                        casin_v,
   input  logic [GOE_W-1:0]            goe_v,
   input  logic [5*NCELLS-1:0]         pt_route_mux,
   input  logic [NCELLS-1:0]           cas_en_mux,
   input  logic [NCELLS-1:0]           xor_inv_mux,
   input  logic [2*NCELLS-1:0]         storage_mux,
   input  logic [NCELLS-1:0]           o_mux,
   input  logic [NCELLS-1:0]           fb_mux,
   input  logic [OESEL_W*NCELLS-1:0]   oe_mux,
   output logic                        casout_v,
   output logic [NCELLS-1:0]           pad_v,
   output logic [NCELLS-1:0]           pad_oe_v,
   output logic [NCELLS-1:0]           mc_fb_v,
   output logic [NCELLS-1:0]           q_v
);

   typedef enum logic [1:0] {
      MODE_D      = 2'b00,
      MODE_T      = 2'b01,
      MODE_STICKY = 2'b10,
      MODE_LOAD   = 2'b11
   } storage_mode_t;

   logic [NCELLS-1:0] sum_c;
   logic [NCELLS-1:0] d_c;
   logic [NCELLS-1:0] xorop_c;
   logic [NCELLS-1:0] ce_c;
   logic [NCELLS-1:0] ar_c;
   logic [NCELLS-1:0] as_c;
   logic [NCELLS-1:0] pt5_oe_c;
   logic [NCELLS-1:0] q_r;
   logic [NCELLS-1:0] q_next;
   logic [NCELLS-1:0] oe_c;
   logic [NCELLS-1:0] raw_c;
   logic              chain;
   storage_mode_t     mode;
   logic [OESEL_W-1:0] sel;

   // The cascade ripples through every cell inside one block so the chain stays a plain variable.
   always_comb begin
      sum_c = '0;
      chain = casin_v;
      for (int i = 0; i < NCELLS; i++) begin
         sum_c[i] = cas_en_mux[i] & chain;
         for (int k = 0; k < 5; k++) begin
            if (!pt_route_mux[5*i+k])
               sum_c[i] = sum_c[i] | pt_v[5*i+k];
         end
         chain = sum_c[i];
      end
   end

   assign casout_v = sum_c[NCELLS-1];

   always_comb begin
      xorop_c  = '0;
      ce_c     = '1;
      ar_c     = '0;
      as_c     = '0;
      pt5_oe_c = '0;
      for (int i = 0; i < NCELLS; i++) begin
         xorop_c[i]  = pt_route_mux[5*i]   & pt_v[5*i];
         ce_c[i]     = ~pt_route_mux[5*i+1] | pt_v[5*i+1];
         ar_c[i]     = pt_route_mux[5*i+2] & pt_v[5*i+2];
         as_c[i]     = pt_route_mux[5*i+3] & pt_v[5*i+3];
         pt5_oe_c[i] = pt_route_mux[5*i+4] & pt_v[5*i+4];
      end
   end

   assign d_c = sum_c ^ xorop_c ^ xor_inv_mux;

   // Clear beats preset; transparent-load is the only mode that ignores CE.
   always_comb begin
      q_next = q_r;
      mode   = MODE_D;
      for (int i = 0; i < NCELLS; i++) begin
         mode = storage_mode_t'(storage_mux[2*i +: 2]);
         if (ar_c[i])
            q_next[i] = 1'b0;
         else if (as_c[i])
            q_next[i] = 1'b1;
         else if (!ce_c[i] && mode != MODE_LOAD)
            q_next[i] = q_r[i];
         else begin
            case (mode)
               MODE_D:      q_next[i] = d_c[i];
               MODE_T:      q_next[i] = q_r[i] ^ d_c[i];
               MODE_STICKY: q_next[i] = q_r[i] | d_c[i];
               default:     q_next[i] = d_c[i];
            endcase
         end
      end
   end

   always_ff @(posedge gclk_v) begin
      if (gclr_v)
         q_r <= '0;
      else
         q_r <= q_next;
   end

   assign q_v     = q_r;
   assign mc_fb_v = (fb_mux & q_r) | (~fb_mux & d_c);
   assign raw_c   = (o_mux & q_r) | (~o_mux & d_c);

   // Select codes past the last global line decode to off.
   always_comb begin
      oe_c = '0;
      sel  = '0;
      for (int i = 0; i < NCELLS; i++) begin
         sel = oe_mux[OESEL_W*i +: OESEL_W];
         if (sel == OESEL_W'(1))
            oe_c[i] = 1'b1;
         else if (sel == OESEL_W'(2))
            oe_c[i] = pt5_oe_c[i];
         for (int g = 0; g < GOE_W; g++) begin
            if (sel == OESEL_W'(g + 3))
               oe_c[i] = goe_v[g];
         end
      end
   end

   assign pad_oe_v = oe_c;

`ifdef MACROCELL_BANK_PIN_KEEPER_EN
   logic [NCELLS-1:0] keeper_r;

   always_ff @(posedge gclk_v) begin
      if (gclr_v)
         keeper_r <= '0;
      else
         keeper_r <= (oe_c & raw_c) | (~oe_c & keeper_r);
   end

   assign pad_v = (oe_c & raw_c) | (~oe_c & keeper_r);
`else
   assign pad_v = oe_c & raw_c;
`endif

endmodule

// File: tb/tb_macrocell_bank.sv
// Directed bench for a 4-cell macrocell_bank with hand-computed expectations.
module tb_macrocell_bank;

   localparam int NCELLS  = 4;
   localparam int GOE_W   = 6;
   localparam int OESEL_W = 4;

   logic                      gclk_v;
   logic                      gclr_v;
   logic [5*NCELLS-1:0]       pt_v;
   logic                      casin_v;
   logic [GOE_W-1:0]          goe_v;
   logic [5*NCELLS-1:0]       pt_route_mux;
   logic [NCELLS-1:0]         cas_en_mux;
   logic [NCELLS-1:0]         xor_inv_mux;
   logic [2*NCELLS-1:0]       storage_mux;
   logic [NCELLS-1:0]         o_mux;
   logic [NCELLS-1:0]         fb_mux;
   logic [OESEL_W*NCELLS-1:0] oe_mux;
   logic                      casout_v;
   logic [NCELLS-1:0]         pad_v;
   logic [NCELLS-1:0]         pad_oe_v;
   logic [NCELLS-1:0]         mc_fb_v;
   logic [NCELLS-1:0]         q_v;

   int vector_count = 0;
   int miss_count   = 0;

   macrocell_bank #(.NCELLS(NCELLS), .GOE_W(GOE_W), .OESEL_W(OESEL_W)) dut (
      .gclk_v(gclk_v), .gclr_v(gclr_v), .pt_v(pt_v), .casin_v(casin_v), .goe_v(goe_v),
      .pt_route_mux(pt_route_mux), .cas_en_mux(cas_en_mux), .xor_inv_mux(xor_inv_mux),
      .storage_mux(storage_mux), .o_mux(o_mux), .fb_mux(fb_mux), .oe_mux(oe_mux),
      .casout_v(casout_v), .pad_v(pad_v), .pad_oe_v(pad_oe_v), .mc_fb_v(mc_fb_v), .q_v(q_v)
   );

   initial gclk_v = 1'b0;
   always #5 gclk_v = ~gclk_v;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5*NCELLS-1:0] pt);
      pt_v = pt;
      #1;
   endtask

   task automatic clockEdge();
      @(posedge gclk_v);
      #1;
   endtask

   task automatic clearBank();
      gclr_v = 1'b1;
      clockEdge();
      gclr_v = 1'b0;
   endtask

   initial begin
      gclr_v = 1'b1; pt_v = '0; casin_v = 1'b0; goe_v = '0;
      pt_route_mux = '0; cas_en_mux = '0; xor_inv_mux = '0; storage_mux = '0;
      o_mux = 4'hF; fb_mux = '0; oe_mux = 16'h1111;
      clockEdge();
      gclr_v = 1'b0;
      #1;
      checkOutput("reset_q", q_v, 4'h0);
      checkOutput("reset_oe", pad_oe_v, 4'hF);
      checkOutput("reset_pad", pad_v, 4'h0);
      checkOutput("reset_casout", casout_v, 1'b0);

      // D mode pulse on cell 0
      applyStimulus(20'h00001);
      checkOutput("d_fb_comb", mc_fb_v, 4'b0001);
      clockEdge();
      checkOutput("d_q_load", q_v, 4'b0001);
      checkOutput("d_pad", pad_v, 4'b0001);
      applyStimulus(20'h00000);
      clockEdge();
      checkOutput("d_q_clear", q_v, 4'b0000);

      // T mode toggling, then global clear where a toggle would give 1
      storage_mux = 8'b01;
      applyStimulus(20'h00001);
      clockEdge(); checkOutput("t_edge1", q_v, 4'b0001);
      clockEdge(); checkOutput("t_edge2", q_v, 4'b0000);
      clockEdge(); checkOutput("t_edge3", q_v, 4'b0001);
      clockEdge(); checkOutput("t_edge4", q_v, 4'b0000);
      clearBank();
      checkOutput("t_gclr", q_v, 4'b0000);
      clockEdge(); checkOutput("t_resume", q_v, 4'b0001);
      applyStimulus(20'h00000);
      storage_mux = 8'b00;
      clearBank();

      // AR/AS priority
      pt_route_mux = 20'b1100;
      applyStimulus(20'b1000);
      clockEdge(); checkOutput("as_set", q_v, 4'b0001);
      applyStimulus(20'b1100);
      clockEdge(); checkOutput("ar_wins", q_v, 4'b0000);
      applyStimulus(20'b1000);
      clockEdge(); checkOutput("as_again", q_v, 4'b0001);

      // CE low holds in D mode, ignored in transparent-load
      pt_route_mux = 20'b1110;
      applyStimulus(20'b0000);
      clockEdge(); checkOutput("ce_hold", q_v, 4'b0001);
      storage_mux = 8'b11;
      #1;
      clockEdge(); checkOutput("load_ignores_ce", q_v, 4'b0000);
      storage_mux = 8'b00;
      applyStimulus(20'b0001);
      clockEdge(); checkOutput("ce_hold_d1", q_v, 4'b0000);
      applyStimulus(20'b0011);
      clockEdge(); checkOutput("ce_enable", q_v, 4'b0001);

      // XOR operand and inversion
      pt_route_mux = 20'b0001;
      applyStimulus(20'b0001);
      checkOutput("xorop_d", mc_fb_v, 4'b0001);
      xor_inv_mux = 4'b0001;
      #1;
      checkOutput("xor_inv_d", mc_fb_v, 4'b0000);
      xor_inv_mux = '0; pt_route_mux = '0;
      applyStimulus(20'h00000);
      clearBank();

      // Cascade chain
      cas_en_mux = 4'b1110;
      applyStimulus(20'h00001);
      checkOutput("cas_out_hi", casout_v, 1'b1);
      checkOutput("cas_fb_all", mc_fb_v, 4'hF);
      applyStimulus(20'h00000);
      checkOutput("cas_out_lo", casout_v, 1'b0);
      casin_v = 1'b1;
      #1;
      checkOutput("cas_in_blocked", casout_v, 1'b0);
      cas_en_mux = 4'b1111;
      #1;
      checkOutput("cas_in_through", casout_v, 1'b1);
      gclr_v = 1'b1;
      clockEdge();
      checkOutput("cas_gclr_q", q_v, 4'h0);
      checkOutput("cas_gclr_chain", casout_v, 1'b1);
      gclr_v = 1'b0;
      clockEdge();
      checkOutput("cas_q_load", q_v, 4'hF);
      casin_v = 1'b0; cas_en_mux = '0;
      clearBank();

      // OE select on cell 1, combinational pad source
      o_mux = 4'b1101;
      oe_mux = 16'h1131;
      goe_v = 6'b000001;
      applyStimulus(20'h00020);
      checkOutput("oe_goe0_on", pad_oe_v, 4'hF);
      checkOutput("oe_goe0_pad", pad_v, 4'b0010);
      goe_v = 6'b000000;
      #1;
      checkOutput("oe_goe0_off", pad_oe_v, 4'b1101);
      checkOutput("oe_goe0_pad_off", pad_v, 4'b0000);
      oe_mux = 16'h11F1;
      #1;
      checkOutput("oe_sel15", pad_oe_v, 4'b1101);
      oe_mux = 16'h1121;
      #1;
      checkOutput("oe_pt5_unrouted", pad_oe_v, 4'b1101);
      pt_route_mux = 20'h00200;
      applyStimulus(20'h00220);
      checkOutput("oe_pt5_on", pad_oe_v, 4'hF);
      checkOutput("oe_pt5_pad", pad_v, 4'b0010);
      oe_mux = 16'h1181;
      goe_v = 6'b100000;
      #1;
      checkOutput("oe_goe5_on", pad_oe_v, 4'hF);
      goe_v = 6'b011111;
      #1;
      checkOutput("oe_goe5_off", pad_oe_v, 4'b1101);
      oe_mux = 16'h1191;
      goe_v = 6'b111111;
      #1;
      checkOutput("oe_sel9_off", pad_oe_v, 4'b1101);

      // Disabled pad: keeper holds the last driven value, otherwise reads 0
      pt_route_mux = '0;
      oe_mux = 16'h1111;
      applyStimulus(20'h00020);
      clockEdge();
      oe_mux = 16'h1101;
      #1;
      checkOutput("keep_oe", pad_oe_v, 4'b1101);
`ifdef MACROCELL_BANK_PIN_KEEPER_EN
      checkOutput("keep_hold", pad_v, 4'b0010);
      clearBank();
      checkOutput("keep_gclr", pad_v, 4'b0000);
`else
      checkOutput("nokeep_pad", pad_v, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule

// File: doc/macrocell_bank.md
Name: macrocell_bank

Overview:
- Parametrised array of NCELLS macrocells sharing one global clock, global clear and output-enable pool.
- Each cell has five product-term inputs with per-PT routing into the OR sum or onto a special function, and an inter-cell cascade chain.
- Storage element has four selectable modes; clock enable, set and clear are all synchronous.
- Sits between the product-term array model and the pad/feedback model; replaces hand-instantiated single cells.

Parameters:
NCELLS, 16, number of macrocells in the bank (1..64)
GOE_W, 6, number of global output-enable lines
OESEL_W, 4, width of per-cell OE select field; must satisfy 2^OESEL_W >= GOE_W+3

Ports:
gclk_v  in  1  global clock, rising edge
gclr_v  in  1  global clear; synchronous, active-high, resets every cell
pt_v  in  5*NCELLS  product terms; cell i PTk at bit 5*i+(k-1)
casin_v  in  1  cascade input into cell 0
goe_v  in  GOE_W  global output enables
pt_route_mux  in  5*NCELLS  per PT: 0 = into sum, 1 = special function
cas_en_mux  in  NCELLS  1 = cell ORs cascade-in into its sum
xor_inv_mux  in  NCELLS  invert D path
storage_mux  in  2*NCELLS  storage mode, cell i at bits 2i+1:2i
o_mux  in  NCELLS  pad source: 1 = register, 0 = combinational
fb_mux  in  NCELLS  feedback source: 1 = register, 0 = combinational
oe_mux  in  OESEL_W*NCELLS  OE select per cell
casout_v  out  1  cascade out of last cell
pad_v  out  NCELLS  pad value
pad_oe_v  out  NCELLS  pad drive enable
mc_fb_v  out  NCELLS  feedback to the interconnect
q_v  out  NCELLS  register state, for observation

Behaviour:
- Per-cell combinational path:
  - sum_i = OR of PTs whose route bit is 0, OR (cas_en_mux[i] & cin_i).
  - cin_0 = casin_v; cin_i = sum_(i-1). casout_v = sum_(NCELLS-1).
  - Chain is purely combinational; zero latency end to end.
- PT special functions when the route bit is 1 (the PT is also excluded from sum):
  - PT1: XOR operand.
  - PT2: clock enable (CE).
  - PT3: synchronous clear (AR).
  - PT4: synchronous preset (AS).
  - PT5: OE source.
- Unrouted specials read as inactive: XOR operand 0, CE 1, AR 0, AS 0, PT5-OE 0.
- d_i = sum_i ^ xorop_i ^ xor_inv_mux[i].
- Register update at each gclk_v rising edge, strict priority:
  1. gclr_v=1 -> q=0 in every cell, regardless of any other input.
  2. AR=1 -> q=0. AR wins when AR and AS are both 1.
  3. AS=1 -> q=1.
  4. CE=0 and mode != 11 -> hold.
  5. Otherwise apply the storage mode.
- Storage modes:
  - 00 D: q <= d.
  - 01 T: q <= q ^ d.
  - 10 sticky-set: q <= q | d.
  - 11 transparent-load: q <= d, ignores CE; still obeys gclr/AR/AS.
- Register latency: 1 cycle from PT change to q_v.
- Outputs:
  - q_v = q.
  - mc_fb_v = fb_mux ? q : d.
  - Raw pad value r_i = o_mux ? q : d.
- OE select value s:
  - 0 -> off.
  - 1 -> on.
  - 2 -> PT5 special (0 if PT5 is not routed).
  - 3..GOE_W+2 -> goe_v[s-3].
  - Values above GOE_W+2 -> off.
- pad_oe_v[i] = selected OE; pad_v[i] = pad_oe_v[i] ? r_i : 0 (without the optional feature).
- Reset values, held in the cycle after gclr_v: q_v=0, keeper state=0. mc_fb_v/pad_v then follow combinational inputs.
- Reset mid-cascade: gclr_v affects only registers; the combinational chain is unaffected.
- Config (_mux) inputs are treated as static; a change takes effect combinationally, with no glitch filtering.

Optional Feature:
- Macro: MACROCELL_BANK_PIN_KEEPER_EN
- Defined:
  - Each cell has a keeper flop, loaded with r_i on every edge where pad_oe_v[i]=1.
  - When pad_oe_v[i]=0, pad_v[i] = keeper value.
  - gclr_v clears the keeper to 0.
- Undefined: no keeper flop; a disabled pad reads 0.

Test Plan:
1. D mode: cell 0 all PTs routed to sum, o_mux=1, oe=1. Pulse PT1=1 for one cycle -> q_v[0]=1 one edge later, 0 the edge after.
2. T mode (01) with PT1=1 held -> q_v toggles 0,1,0,1 on successive edges; gclr_v=1 mid-sequence -> q=0 on that edge.
3. PT3 and PT4 routed, both 1 in the same cycle -> q=0; then PT3=0 -> q=1. PT2 routed and 0 in mode 00 -> q holds; in mode 11 -> q loads d.
4. Cascade: NCELLS=4, cas_en_mux=4'b1110, casin_v=0, only cell 0 PT1=1 -> casout_v=1 in the same cycle. Cell 0 sum back to 0 -> casout_v=0.
5. OE select: s=3 with goe_v=6'b000001 -> pad driven; goe_v=0 -> pad_oe_v=0, pad_v=0. s=15 -> off.
6. With MACROCELL_BANK_PIN_KEEPER_EN: drive pad to 1, then disable OE -> pad_v stays 1. gclr_v -> pad_v=0.
